clint_irq_ctrl: RTL and testbench

//  Parametrised machine-mode trap controller for the single-issue core; generalises CLINT to N local IRQ lines.

---
 rtl/clint_pkg.sv | 36 +++
 rtl/clint_irq_prio.sv | 46 ++++
 rtl/clint_irq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_clint_irq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared constants for the CLINT trap controller: CSR addresses, cause codes,
// SYSTEM instruction encodings, mstatus/mie bit positions and the FSM state type.
package clint_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [4:0] CODE_MSI       = 5'd3;
    localparam logic [4:0] CODE_MTI       = 5'd7;
    localparam logic [4:0] CODE_MEI       = 5'd11;
    localparam logic [4:0] CODE_LIRQ_BASE = 5'd16;
    localparam logic [4:0] CAUSE_ECALL    = 5'd11;
    localparam logic [4:0] CAUSE_EBREAK   = 5'd3;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam int MSTATUS_MIE   = 3;
    localparam int MSTATUS_MPIE  = 7;
    localparam int MIE_MSI       = 3;
    localparam int MIE_MTI       = 7;
    localparam int MIE_MEI       = 11;
    localparam int MIE_LIRQ_BASE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MSTATUS,
        ST_WR_MEPC,
        ST_WR_MCAUSE,
        ST_MRET_MSTATUS,
        ST_ASSERT
    } state_t;

endpackage

// File: rtl/clint_irq_prio.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI > L[0] > ... > L[N-1].
// Purely combinational; a line counts only when its mie enable bit is set.
module clint_irq_prio
    import clint_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_LIRQ = 4
) (
    input  logic                meip,
    input  logic                msip,
    input  logic                mtip,
    input  logic [NUM_LIRQ-1:0] lirq,
    input  logic [XLEN-1:0]     mie,
    output logic                valid,
    output logic [4:0]          code
);

    // Only a subset of mie bits are enables; the rest are reduced away here.
    logic unused_mie;
    assign unused_mie = ^mie;

    // Walk lowest priority first so higher-priority sources overwrite it.
    always_comb begin
        valid = 1'b0;
        code  = '0;
        for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
            if (lirq[i] && mie[MIE_LIRQ_BASE + i]) begin
                valid = 1'b1;
                code  = CODE_LIRQ_BASE + 5'(i);
            end
        end
        if (mtip && mie[MIE_MTI]) begin
            valid = 1'b1;
            code  = CODE_MTI;
        end
        if (msip && mie[MIE_MSI]) begin
            valid = 1'b1;
            code  = CODE_MSI;
        end
        if (meip && mie[MIE_MEI]) begin
            valid = 1'b1;
            code  = CODE_MEI;
        end
    end

endmodule

// File: rtl/clint_irq_ctrl.sv
// Machine-mode trap controller: arbitrates interrupts and ecall/ebreak/mret, sequences
// mstatus/mepc/mcause writes, then redirects EX. Define CLINT_VECTORED_EN for vectored mtvec.
module clint_irq_ctrl
    import clint_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_LIRQ = 4,
    parameter int CSR_AW   = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                meip_i,
    input  logic                msip_i,
    input  logic                mtip_i,
    input  logic [NUM_LIRQ-1:0] lirq_i,
    input  logic                inst_valid_i,
    input  logic [31:0]         inst_i,
    input  logic [XLEN-1:0]     inst_addr_i,
    input  logic                jump_flag_i,
    input  logic [XLEN-1:0]     jump_addr_i,
    input  logic [XLEN-1:0]     csr_mstatus_i,
    input  logic [XLEN-1:0]     csr_mie_i,
    input  logic [XLEN-1:0]     csr_mtvec_i,
    input  logic [XLEN-1:0]     csr_mepc_i,
    output logic                hold_flag_o,
    output logic                csr_we_o,
    output logic [CSR_AW-1:0]   csr_waddr_o,
    output logic [XLEN-1:0]     csr_wdata_o,
    output logic                int_flag_o,
    output logic [XLEN-1:0]     int_addr_o
);

    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r               = v;
        r[MSTATUS_MPIE] = v[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r               = v;
        r[MSTATUS_MIE]  = v[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

    state_t          state_q, state_d;
    logic            irq_valid;
    logic [4:0]      irq_code;
    logic [XLEN-1:0] epc_q, cause_q;
    logic            mret_q;
    logic            idle, dec_ok, is_ecall, is_ebreak, is_mret;
    logic            take_irq, take_sync, take_mret, detect;
    logic [XLEN-1:0] trap_base, trap_target;

    clint_irq_prio #(
        .XLEN     (XLEN),
        .NUM_LIRQ (NUM_LIRQ)
    ) u_prio (
        .meip  (meip_i),
        .msip  (msip_i),
        .mtip  (mtip_i),
        .lirq  (lirq_i),
        .mie   (csr_mie_i),
        .valid (irq_valid),
        .code  (irq_code)
    );

    assign idle      = (state_q == ST_IDLE);
    assign dec_ok    = inst_valid_i & ~jump_flag_i;
    assign is_ecall  = dec_ok & (inst_i == INST_ECALL);
    assign is_ebreak = dec_ok & (inst_i == INST_EBREAK);
    assign is_mret   = dec_ok & (inst_i == INST_MRET);

    // Interrupts win over a same-cycle SYSTEM instruction, which re-executes after return.
    assign take_irq  = idle & ~rst & irq_valid & csr_mstatus_i[MSTATUS_MIE];
    assign take_sync = idle & ~rst & ~take_irq & (is_ecall | is_ebreak);
    assign take_mret = idle & ~rst & ~take_irq & is_mret;
    assign detect    = take_irq | take_sync | take_mret;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take_irq || take_sync) state_d = ST_WR_MSTATUS;
                else if (take_mret)        state_d = ST_MRET_MSTATUS;
            end
            ST_WR_MSTATUS:   state_d = ST_WR_MEPC;
            ST_WR_MEPC:      state_d = ST_WR_MCAUSE;
            ST_WR_MCAUSE:    state_d = ST_ASSERT;
            ST_MRET_MSTATUS: state_d = ST_ASSERT;
            ST_ASSERT:       state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // Trap context is captured only in the detect cycle; later input changes cannot cancel it.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q   <= '0;
            cause_q <= '0;
            mret_q  <= 1'b0;
        end else if (take_irq) begin
            epc_q   <= jump_flag_i ? jump_addr_i : inst_addr_i;
            cause_q <= {1'b1, {(XLEN-6){1'b0}}, irq_code};
            mret_q  <= 1'b0;
        end else if (take_sync) begin
            epc_q   <= inst_addr_i;
            cause_q <= XLEN'(is_ecall ? CAUSE_ECALL : CAUSE_EBREAK);
            mret_q  <= 1'b0;
        end else if (take_mret) begin
            mret_q  <= 1'b1;
        end
    end

    assign trap_base = {csr_mtvec_i[XLEN-1:2], 2'b00};
`ifdef CLINT_VECTORED_EN
    assign trap_target = (cause_q[XLEN-1] && csr_mtvec_i[1:0] == 2'b01)
                       ? trap_base + (XLEN'(cause_q[4:0]) << 2) : trap_base;
`else
    logic unused_mode;
    assign unused_mode = ^csr_mtvec_i[1:0];
    assign trap_target = trap_base;
`endif

    always_comb begin
        hold_flag_o = detect | ~idle;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        int_flag_o  = 1'b0;
        int_addr_o  = '0;
        case (state_q)
            ST_WR_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                csr_wdata_o = trap_mstatus(csr_mstatus_i);
            end
            ST_WR_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_AW'(CSR_MEPC);
                csr_wdata_o = epc_q;
            end
            ST_WR_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_AW'(CSR_MCAUSE);
                csr_wdata_o = cause_q;
            end
            ST_MRET_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                csr_wdata_o = mret_mstatus(csr_mstatus_i);
            end
            ST_ASSERT: begin
                int_flag_o = 1'b1;
                int_addr_o = mret_q ? csr_mepc_i : trap_target;
            end
            default: ;
        endcase
        // Reset forces a quiet interface even while the state register is still mid-sequence.
        if (rst) begin
            hold_flag_o = 1'b0;
            csr_we_o    = 1'b0;
            csr_waddr_o = '0;
            csr_wdata_o = '0;
            int_flag_o  = 1'b0;
            int_addr_o  = '0;
        end
    end

endmodule

// File: tb/tb_clint_irq_ctrl.sv
// Self-checking bench for clint_irq_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_clint_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        meip, msip, mtip;
    logic [3:0]  lirq;
    logic        inst_valid;
    logic [31:0] inst, inst_addr, jump_addr;
    logic        jump_flag;
    logic [31:0] csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
    logic        hold_flag_o, csr_we_o, int_flag_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o, int_addr_o;

    always #5 clk = ~clk;

    clint_irq_ctrl #(.XLEN(32), .NUM_LIRQ(4), .CSR_AW(12)) dut (
        .clk           (clk),
        .rst           (rst),
        .meip_i        (meip),
        .msip_i        (msip),
        .mtip_i        (mtip),
        .lirq_i        (lirq),
        .inst_valid_i  (inst_valid),
        .inst_i        (inst),
        .inst_addr_i   (inst_addr),
        .jump_flag_i   (jump_flag),
        .jump_addr_i   (jump_addr),
        .csr_mstatus_i (csr_mstatus),
        .csr_mie_i     (csr_mie),
        .csr_mtvec_i   (csr_mtvec),
        .csr_mepc_i    (csr_mepc),
        .hold_flag_o   (hold_flag_o),
        .csr_we_o      (csr_we_o),
        .csr_waddr_o   (csr_waddr_o),
        .csr_wdata_o   (csr_wdata_o),
        .int_flag_o    (int_flag_o),
        .int_addr_o    (int_addr_o)
    );

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;

    typedef struct packed {
        logic        hold;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        flag;
        logic [31:0] iaddr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int          step_n, flag_step, flag_cnt;
    logic [31:0] cap_ms, cap_epc, cap_cause, flag_addr;
    logic        cause_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic h, input logic w, input logic [11:0] a,
                                input logic [31:0] d, input logic f, input logic [31:0] ia);
        exp_t e;
        e.hold = h; e.we = w; e.waddr = a; e.wdata = d; e.flag = f; e.iaddr = ia;
        return e;
    endfunction

    // Reference model: decides what the controller must do from the architectural rules,
    // and queues the whole per-cycle output script of the resulting transaction.
    task automatic model_detect();
        int          code;
        bit          irq, sync_ok, trap, ret;
        logic [31:0] epc, cause, tgt, ms;
        irq  = 0;
        code = 0;
        if (csr_mstatus[3]) begin
            if (meip && csr_mie[11])      begin irq = 1; code = 11; end
            else if (msip && csr_mie[3])  begin irq = 1; code = 3;  end
            else if (mtip && csr_mie[7])  begin irq = 1; code = 7;  end
            else begin
                for (int i = 0; i < 4; i++)
                    if (!irq && lirq[i] && csr_mie[16+i]) begin irq = 1; code = 16 + i; end
            end
        end
        sync_ok = inst_valid && !jump_flag;
        trap    = irq || (sync_ok && (inst == ECALL || inst == EBREAK));
        ret     = !irq && sync_ok && inst == MRET;
        tgt     = {csr_mtvec[31:2], 2'b00};
`ifdef CLINT_VECTORED_EN
        if (irq && csr_mtvec[1:0] == 2'b01) tgt = tgt + 32'(4 * code);
`endif
        if (trap) begin
            epc   = irq ? (jump_flag ? jump_addr : inst_addr) : inst_addr;
            cause = irq ? (32'h8000_0000 | 32'(code)) : (inst == ECALL ? 32'd11 : 32'd3);
            ms    = (csr_mstatus & ~32'h88) | (csr_mstatus[3] ? 32'h80 : 32'h0);
            exp_q.push_back(mk(1, 0, 12'h0,   32'h0, 0, 32'h0));
            exp_q.push_back(mk(1, 1, 12'h300, ms,    0, 32'h0));
            exp_q.push_back(mk(1, 1, 12'h341, epc,   0, 32'h0));
            exp_q.push_back(mk(1, 1, 12'h342, cause, 0, 32'h0));
            exp_q.push_back(mk(1, 0, 12'h0,   32'h0, 1, tgt));
        end else if (ret) begin
            ms = (csr_mstatus & ~32'h88) | (csr_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
            exp_q.push_back(mk(1, 0, 12'h0,   32'h0, 0, 32'h0));
            exp_q.push_back(mk(1, 1, 12'h300, ms,    0, 32'h0));
            exp_q.push_back(mk(1, 0, 12'h0,   32'h0, 1, csr_mepc));
        end else begin
            exp_q.push_back(mk(0, 0, 12'h0, 32'h0, 0, 32'h0));
        end
    endtask

    task automatic clear_cap();
        step_n = 0; flag_step = -1; flag_cnt = 0; cause_seen = 0;
        cap_ms = 'x; cap_epc = 'x; cap_cause = 'x; flag_addr = 'x;
    endtask

    task automatic step();
        exp_t e;
        #1;
        if (rst) begin
            exp_q.delete();
            e = '0;
        end else begin
            if (exp_q.size() == 0) model_detect();
            e = exp_q.pop_front();
        end
        chk("hold",  32'(hold_flag_o), 32'(e.hold));
        chk("we",    32'(csr_we_o),    32'(e.we));
        chk("waddr", 32'(csr_waddr_o), 32'(e.waddr));
        chk("wdata", csr_wdata_o,      e.wdata);
        chk("flag",  32'(int_flag_o),  32'(e.flag));
        chk("iaddr", int_addr_o,       e.iaddr);
        if (csr_we_o) begin
            if (csr_waddr_o == 12'h300) cap_ms  = csr_wdata_o;
            if (csr_waddr_o == 12'h341) cap_epc = csr_wdata_o;
            if (csr_waddr_o == 12'h342) begin cap_cause = csr_wdata_o; cause_seen = 1; end
        end
        if (int_flag_o) begin flag_step = step_n; flag_addr = int_addr_o; flag_cnt++; end
        @(posedge clk);
        @(negedge clk);
        step_n++;
    endtask

    task automatic quiet();
        rst = 0; meip = 0; msip = 0; mtip = 0; lirq = 0;
        inst_valid = 0; inst = 32'h13; inst_addr = 32'h8000_0000;
        jump_flag = 0; jump_addr = 32'h0;
    endtask

    task automatic rand_inputs();
        rst  = ($urandom_range(0, 299) == 0);
        meip = ($urandom_range(0, 15) == 0);
        msip = ($urandom_range(0, 15) == 0);
        mtip = ($urandom_range(0, 15) == 0);
        for (int i = 0; i < 4; i++) lirq[i] = ($urandom_range(0, 15) == 0);
        inst_valid = $urandom_range(0, 1);
        case ($urandom_range(0, 4))
            0:       inst = ECALL;
            1:       inst = EBREAK;
            2:       inst = MRET;
            default: inst = $urandom;
        endcase
        inst_addr = $urandom & ~32'h3;
        jump_flag = ($urandom_range(0, 3) == 0);
        jump_addr = $urandom & ~32'h3;
        if (exp_q.size() == 0) begin
            csr_mstatus = $urandom;
            csr_mie     = $urandom;
            csr_mtvec   = $urandom;
            csr_mepc    = $urandom;
        end
    endtask

    initial begin
        quiet();
        csr_mstatus = 0; csr_mie = 0; csr_mtvec = 0; csr_mepc = 0;
        rst = 1;
        @(negedge clk);
        clear_cap();
        step();
        step();
        rst = 0;
        step();

        // External interrupt taken with MIE set
        clear_cap();
        csr_mstatus = 32'h8; csr_mie = 32'h800; csr_mtvec = 32'h8000_1000;
        meip = 1; inst_addr = 32'h8000_0010;
        step(); meip = 0;
        repeat (5) step();
        chk("mei_ms",    cap_ms,    32'h80);
        chk("mei_epc",   cap_epc,   32'h8000_0010);
        chk("mei_cause", cap_cause, 32'h8000_000B);
        chk("mei_lat",   32'(flag_step), 32'd4);
        chk("mei_tgt",   flag_addr, 32'h8000_1000);

        // ecall with MIE clear, then mret restores MIE from MPIE
        clear_cap();
        csr_mstatus = 32'h80;
        inst_valid = 1; inst = ECALL; inst_addr = 32'h8000_0100;
        step(); inst_valid = 0;
        repeat (5) step();
        chk("ecall_ms",    cap_ms,    32'h0);
        chk("ecall_epc",   cap_epc,   32'h8000_0100);
        chk("ecall_cause", cap_cause, 32'd11);
        clear_cap();
        csr_mstatus = 32'h80; csr_mepc = 32'h8000_0104;
        inst_valid = 1; inst = MRET;
        step(); inst_valid = 0;
        repeat (3) step();
        chk("mret_ms",  cap_ms,    32'h88);
        chk("mret_lat", 32'(flag_step), 32'd2);
        chk("mret_tgt", flag_addr, 32'h8000_0104);

        // Priority among simultaneous sources, then a lone low-priority local line
        clear_cap();
        csr_mstatus = 32'h8; csr_mie = 32'hFFFF_FFFF;
        msip = 1; mtip = 1; lirq = 4'b0001;
        step(); msip = 0; mtip = 0; lirq = 0;
        repeat (5) step();
        chk("prio_cause", cap_cause, 32'h8000_0003);
        clear_cap();
        lirq = 4'b0100;
        step(); lirq = 0;
        repeat (5) step();
        chk("lirq2_cause", cap_cause, 32'h8000_0012);

        // Interrupt during an EX redirect saves the redirect target; ecall alone under redirect ignored
        clear_cap();
        csr_mie = 32'h80; mtip = 1;
        jump_flag = 1; jump_addr = 32'h8000_0200;
        inst_valid = 1; inst = ECALL; inst_addr = 32'h8000_0300;
        step(); mtip = 0; inst_valid = 0; jump_flag = 0;
        repeat (5) step();
        chk("jmp_epc",   cap_epc,   32'h8000_0200);
        chk("jmp_cause", cap_cause, 32'h8000_0007);
        chk("jmp_once",  32'(flag_cnt), 32'd1);
        clear_cap();
        jump_flag = 1; inst_valid = 1; inst = ECALL;
        step(); jump_flag = 0; inst_valid = 0;
        step();
        chk("jmp_ecall_none", 32'(flag_cnt), 32'd0);

        // Reset while writing mepc aborts the sequence
        clear_cap();
        csr_mstatus = 32'h8; csr_mie = 32'h800; meip = 1;
        step(); meip = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        repeat (5) step();
        chk("rst_no_cause", 32'(cause_seen), 32'd0);
        chk("rst_no_flag",  32'(flag_cnt),   32'd0);

        // Vectored mtvec: async uses base+4*code, sync uses base
        clear_cap();
        csr_mstatus = 32'h8; csr_mie = 32'h80; csr_mtvec = 32'h8000_1001; mtip = 1;
        step(); mtip = 0;
        repeat (5) step();
`ifdef CLINT_VECTORED_EN
        chk("vec_async", flag_addr, 32'h8000_101C);
`else
        chk("vec_async", flag_addr, 32'h8000_1000);
`endif
        clear_cap();
        inst_valid = 1; inst = ECALL;
        step(); inst_valid = 0;
        repeat (5) step();
        chk("vec_sync", flag_addr, 32'h8000_1000);

        // Randomized traffic against the model
        repeat (3000) begin
            rand_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
